// File: rtl/multi_string_matcher.sv
// Multi-pattern byte-stream matcher: NUM_PATTERNS programmable strings are
// searched at every byte alignment of a 32-bit stream. Sticky per-slot flags
// are raised, and the stream is forwarded through a fixed delay line.

// One pattern slot: holds its pattern and compares it against the byte window.
module msm_slot #(
  parameter int MAX_LEN = 17,
  parameter int WB      = 20,   // window bytes, index 0 = newest byte
  parameter int FW      = 5,
  parameter int LW      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [MAX_LEN*8-1:0]  str_i,
  input  logic [LW-1:0]         len_i,
  input  logic                  en_i,
  input  logic                  nocase_i,
  input  logic                  valid_i,
  input  logic [WB-1:0][7:0]    win_i,
  input  logic [FW-1:0]         fill_i,
  output logic                  match_o,
  output logic                  pulse_o
);
  logic [MAX_LEN-1:0][7:0] str_q;   // str_q[0] is the last pattern char
  logic [LW-1:0]           len_q;
  logic                    en_q;
  logic                    match_q;
  logic                    pulse_q;
  logic [3:0]              off_hit;

  // Upper-case letters fold to lower case when case-insensitive.
  function automatic logic [7:0] fold(input logic [7:0] b, input logic nc);
    fold = (nc && b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

  // Match test for the four end offsets. Byte k of the word sits at window age 3-k;
  // every history byte the pattern reaches back into must have been accepted since clear.
  always_comb begin
    off_hit = '0;
    if (en_q && (|len_q) && int'(len_q) <= MAX_LEN) begin
      for (int k = 0; k < 4; k++) begin
        off_hit[k] = 1'b1;
        if (int'(len_q) - 1 - k > int'(fill_i)) off_hit[k] = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < int'(len_q) &&
              fold(win_i[3-k+j], nocase_i) != fold(str_q[j], nocase_i))
            off_hit[k] = 1'b0;
        end
      end
    end
  end

  // Slot contents and flags; a write to this slot wipes its flags on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      str_q   <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      match_q <= 1'b0;
      pulse_q <= 1'b0;
    end else if (we_i) begin
      str_q   <= str_i;
      len_q   <= len_i;
      en_q    <= en_i;
      match_q <= 1'b0;
      pulse_q <= 1'b0;
    end else if (clear_i) begin
      match_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= valid_i & (|off_hit);
      match_q <= match_q | (valid_i & (|off_hit));
    end
  end

  assign match_o = match_q;
  assign pulse_o = pulse_q;
endmodule

module multi_string_matcher #(
  parameter int NUM_PATTERNS = 4,
  parameter int MAX_LEN      = 17,
  parameter int OUT_LAT      = 5
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             clear_i,
  input  logic                                             data_valid_i,
  input  logic [31:0]                                      data_in_i,
  input  logic                                             pat_we_i,
  input  logic [(NUM_PATTERNS > 1 ? $clog2(NUM_PATTERNS) : 1)-1:0] pat_idx_i,
  input  logic [MAX_LEN*8-1:0]                             pat_str_i,
  input  logic [$clog2(MAX_LEN+1)-1:0]                     pat_len_i,
  input  logic                                             pat_en_i,
  input  logic                                             nocase_i,
  output logic [31:0]                                      data_out_o,
  output logic                                             data_out_valid_o,
  output logic [NUM_PATTERNS-1:0]                          match_o,
  output logic [NUM_PATTERNS-1:0]                          match_pulse_o,
  output logic                                             match_any_o,
  output logic [(NUM_PATTERNS > 1 ? $clog2(NUM_PATTERNS) : 1)-1:0] first_idx_o
);
  localparam int IW   = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int HL   = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;  // history storage bytes
  localparam int HMAX = MAX_LEN - 1;                      // fill count ceiling
  localparam int FW   = $clog2(MAX_LEN + 1);
  localparam int WB   = HL + 4;

  logic [HL-1:0][7:0]      hist_q;     // hist_q[0] is the newest accepted byte
  logic [FW-1:0]           fill_q;
  logic [WB-1:0][7:0]      win;
  logic [OUT_LAT:1][31:0]  dly_q;
  logic [OUT_LAT:1]        vld_pipe;
  logic [IW-1:0]           first_d;

  assign win = {hist_q, data_in_i};

  // History shift and fill count; clear only resets the count, stale bytes are masked by it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      fill_q <= '0;
    end else if (data_valid_i) begin
      hist_q <= win[HL-1:0];
      if (int'(fill_q) + 4 >= HMAX) fill_q <= FW'(HMAX);
      else                          fill_q <= FW'(int'(fill_q) + 4);
    end
  end

  // Free-running delay line for the forwarded stream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q    <= '0;
      vld_pipe <= '0;
    end else begin
      dly_q[1]    <= data_in_i;
      vld_pipe[1] <= data_valid_i;
      for (int s = 2; s <= OUT_LAT; s++) begin
        dly_q[s]    <= dly_q[s-1];
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  assign data_out_o       = dly_q[OUT_LAT];
  assign data_out_valid_o = vld_pipe[OUT_LAT];

  for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_slot
    msm_slot #(.MAX_LEN(MAX_LEN), .WB(WB), .FW(FW), .LW(LW)) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .we_i     (pat_we_i && pat_idx_i == IW'(i)),
      .str_i    (pat_str_i),
      .len_i    (pat_len_i),
      .en_i     (pat_en_i),
      .nocase_i (nocase_i),
      .valid_i  (data_valid_i),
      .win_i    (win),
      .fill_i   (fill_q),
      .match_o  (match_o[i]),
      .pulse_o  (match_pulse_o[i])
    );
  end

  // Lowest set sticky flag wins.
  always_comb begin
    first_d = '0;
    for (int i = NUM_PATTERNS - 1; i >= 0; i--)
      if (match_o[i]) first_d = IW'(i);
  end

  assign first_idx_o = first_d;
  assign match_any_o = |match_o;
endmodule

// File: tb/tb_multi_string_matcher.sv
// Randomized and directed bench for multi_string_matcher against a queue-based model.
module tb_multi_string_matcher;
  localparam int NP = 4;
  localparam int ML = 17;
  localparam int OL = 5;
  localparam int IW = 2;
  localparam int LW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1, clear = 1'b0, data_valid = 1'b0;
  logic [31:0]    data_in = '0;
  logic           pat_we = 1'b0, pat_en = 1'b0, nocase = 1'b0;
  logic [IW-1:0]  pat_idx = '0;
  logic [ML*8-1:0] pat_str = '0;
  logic [LW-1:0]  pat_len = '0;
  logic [31:0]    data_out;
  logic           data_out_valid, match_any;
  logic [NP-1:0]  match, match_pulse;
  logic [IW-1:0]  first_idx;

  multi_string_matcher #(.NUM_PATTERNS(NP), .MAX_LEN(ML), .OUT_LAT(OL)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .data_valid_i(data_valid),
    .data_in_i(data_in), .pat_we_i(pat_we), .pat_idx_i(pat_idx), .pat_str_i(pat_str),
    .pat_len_i(pat_len), .pat_en_i(pat_en), .nocase_i(nocase),
    .data_out_o(data_out), .data_out_valid_o(data_out_valid), .match_o(match),
    .match_pulse_o(match_pulse), .match_any_o(match_any), .first_idx_o(first_idx));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: stream bytes since clear, slot contents, flags, delay queue.
  logic [7:0]  s_q[$];
  logic [7:0]  m_pat[NP][ML];   // m_pat[i][0] is the last char
  int          m_len[NP];
  bit          m_en[NP];
  bit [NP-1:0] m_match, m_pulse;
  logic [32:0] d_q[$];

  function automatic bit is_alpha(input logic [7:0] a);
    return (a >= "A" && a <= "Z") || (a >= "a" && a <= "z");
  endfunction

  function automatic bit ceq(input logic [7:0] a, input logic [7:0] b, input bit nc);
    if (a == b) return 1;
    if (nc && is_alpha(a) && ((a ^ 8'h20) == b)) return 1;
    return 0;
  endfunction

  function automatic bit slot_hit(input int i, input int e);
    int L;
    L = m_len[i];
    if (!m_en[i] || L < 1 || L > ML) return 0;
    if (e - L + 1 < 0) return 0;
    for (int j = 0; j < L; j++)
      if (!ceq(s_q[e-j], m_pat[i][j], nocase)) return 0;
    return 1;
  endfunction

  task automatic model_edge();
    int n;
    if (rst) begin
      s_q.delete();
      d_q.delete();
      for (int s = 0; s < OL; s++) d_q.push_back('0);
      for (int i = 0; i < NP; i++) begin
        m_len[i] = 0; m_en[i] = 0;
        for (int j = 0; j < ML; j++) m_pat[i][j] = '0;
      end
      m_match = '0; m_pulse = '0;
    end else begin
      d_q.push_back({data_valid, data_in});
      while (d_q.size() > OL) void'(d_q.pop_front());
      m_pulse = '0;
      if (clear) begin
        s_q.delete();
        m_match = '0;
      end else if (data_valid) begin
        for (int k = 0; k < 4; k++) s_q.push_back(data_in[31-8*k -: 8]);
        n = s_q.size();
        for (int i = 0; i < NP; i++)
          for (int k = 0; k < 4; k++)
            if (slot_hit(i, n - 4 + k)) m_pulse[i] = 1'b1;
        m_match |= m_pulse;
        while (s_q.size() > 64) void'(s_q.pop_front());
      end
      if (pat_we && int'(pat_idx) < NP) begin
        for (int j = 0; j < ML; j++) m_pat[pat_idx][j] = pat_str[j*8 +: 8];
        m_len[pat_idx] = int'(pat_len);
        m_en[pat_idx]  = pat_en;
        m_match[pat_idx] = 1'b0;
        m_pulse[pat_idx] = 1'b0;
      end
    end
  endtask

  // One clock: edge, model update, full output comparison.
  task automatic cyc();
    int f;
    @(posedge clk);
    #1;
    model_edge();
    f = 0;
    for (int i = NP - 1; i >= 0; i--) if (m_match[i]) f = i;
    check("match", match, m_match);
    check("match_pulse", match_pulse, m_pulse);
    check("match_any", match_any, |m_match);
    check("first_idx", first_idx, f);
    check("data_out", data_out, d_q[0][31:0]);
    check("data_out_valid", data_out_valid, d_q[0][32]);
  endtask

  task automatic send(input logic [31:0] w);
    data_valid = 1'b1; data_in = w;
    cyc();
    data_valid = 1'b0; data_in = $urandom;
  endtask

  task automatic sends(input string s);
    string t;
    t = s;
    while (t.len() % 4 != 0) t = {t, " "};
    for (int i = 0; i < t.len(); i += 4) send({t[i], t[i+1], t[i+2], t[i+3]});
  endtask

  task automatic wr(input int idx, input string s, input int len, input bit en);
    pat_str = '0;
    for (int c = 0; c < s.len(); c++) begin
      pat_str = pat_str << 8;
      pat_str[7:0] = s[c];
    end
    pat_idx = IW'(idx); pat_len = LW'(len); pat_en = en; pat_we = 1'b1;
    cyc();
    pat_we = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  function automatic logic [7:0] rb();
    case ($urandom_range(0, 4))
      0: return 8'h61;  // a
      1: return 8'h41;  // A
      2: return 8'h62;  // b
      3: return 8'h42;  // B
      default: return 8'h5B;  // '[' sits next to Z but is not a letter
    endcase
  endfunction

  initial begin
    string pad;
    // Reset
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_match", match, 0);
    check("rst_dov", data_out_valid, 0);

    // Single long pattern at all four alignments
    wr(0, "www.google.com", 14, 1'b1);
    for (int a = 0; a < 4; a++) begin
      clr();
      pad = "";
      repeat (a) pad = {pad, "x"};
      sends({pad, "www.google.com"});
      check("t2_pulse", match_pulse[0], 1);
      cyc();
      check("t2_pulse_drop", match_pulse[0], 0);
      check("t2_sticky", match[0], 1);
    end

    // Maximum-length pattern plus a short one
    clr();
    wr(1, "www.linkedin.com/", 17, 1'b1);
    wr(2, "abc", 3, 1'b1);
    sends("www.linkedin.com/abc");
    check("t3_match", match, 4'b0110);
    check("t3_first", first_idx, 1);
    check("t3_any", match_any, 1);

    // All-zero pattern vs fill count
    wr(0, "", 17, 1'b1);
    clr();
    repeat (4) send(32'h0);
    check("t4_nofill", match[0], 0);
    send(32'h0);
    check("t4_fill", match[0], 1);
    clr();
    check("t4_clear", match, 0);

    // Case folding and clear boundary
    wr(3, "GET ", 4, 1'b1);
    nocase = 1'b1; clr(); sends("get ");
    check("t5_nocase", match[3], 1);
    nocase = 1'b0; clr(); sends("get ");
    check("t5_case", match[3], 0);
    wr(0, "www.g", 5, 1'b1);
    clr(); send("xxxw"); clr(); send("ww.g");
    check("t5_span", match[0], 0);
    clr(); send("xxxw"); send("ww.g");
    check("t5_nospan", match[0], 1);

    // Near miss, bubbles, write mid-stream
    wr(0, "www.google.com", 14, 1'b1);
    clr(); sends("www.googbook.com");
    check("t6_miss", match[0], 0);
    clr(); send("www."); cyc(); cyc(); send("goog"); cyc(); send("le.c"); send("om  ");
    check("t6_bubble", match[0], 1);
    wr(0, "www.google.com", 14, 1'b1);
    check("t6_wrclr", match[0], 0);

    // Random traffic
    for (int it = 0; it < 4000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      clear = (r < 3);
      if ($urandom_range(0, 99) < 6) begin
        pat_we  = 1'b1;
        pat_idx = IW'($urandom_range(0, NP - 1));
        for (int j = 0; j < ML; j++) pat_str[j*8 +: 8] = rb();
        pat_len = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 31))
                                              : LW'($urandom_range(1, 5));
        pat_en  = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 49) == 0) nocase = ~nocase;
      data_valid = ($urandom_range(0, 9) < 6);
      data_in    = {rb(), rb(), rb(), rb()};
      cyc();
      clear = 1'b0; pat_we = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
